seg7_capture: RTL

- Reads back a time-multiplexed, active-low common-anode 7-segment display bus: the segment lines plus one digit-select line per digit.
- Recovers the hex nibble shown on each digit and assembles a complete multi-digit frame.
- Presents the frame on a valid/ready interface.
- Used as a self-check/loopback monitor on the display outputs and for reading external 7-segment instruments.

---
 rtl/seg7_capture_if.sv | 33 +++
 rtl/seg7_capture.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seg7_capture_if.sv
// Display read-back bus plus frame handshake for seg7_capture.
// master = the capture block, slave = the frame consumer / display driver side.
interface seg7_capture_if #(
  parameter int DIGITS = 4
);
  logic [6:0]          seg_n;
  logic [DIGITS-1:0]   an_n;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   err;
  logic                frame_valid;
  logic                frame_ready;
  logic                overrun;

  modport master (
    input  seg_n,
    input  an_n,
    input  frame_ready,
    output value,
    output err,
    output frame_valid,
    output overrun
  );

  modport slave (
    output seg_n,
    output an_n,
    output frame_ready,
    input  value,
    input  err,
    input  frame_valid,
    input  overrun
  );
endinterface

// File: rtl/seg7_capture.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus into valid/ready frames.
// Optional macro SEG7_CAPTURE_ALT_GLYPH_EN accepts two alternate glyphs for 9 and 7.
module seg7_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic         clk,
  input  logic         resetn,
  seg7_capture_if.master bus
);
  localparam int              W        = 7 + DIGITS;
  localparam logic [7:0]      CNT_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0]      CNT_ARM  = 8'(STABLE_CYCLES - 2);

  // Returns {err, nibble} for an active-high gfedcba pattern.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    logic [4:0] r;
    r = 5'h10;
    case (pat)
      7'b0111111: r = 5'h00;
      7'b0000110: r = 5'h01;
      7'b1011011: r = 5'h02;
      7'b1001111: r = 5'h03;
      7'b1100110: r = 5'h04;
      7'b1101101: r = 5'h05;
      7'b1111101: r = 5'h06;
      7'b0000111: r = 5'h07;
      7'b1111111: r = 5'h08;
      7'b1101111: r = 5'h09;
      7'b1110111: r = 5'h0A;
      7'b1111100: r = 5'h0B;
      7'b0111001: r = 5'h0C;
      7'b1011110: r = 5'h0D;
      7'b1111001: r = 5'h0E;
      7'b1110001: r = 5'h0F;
`ifdef SEG7_CAPTURE_ALT_GLYPH_EN
      7'b1100111: r = 5'h09;
      7'b0100111: r = 5'h07;
`endif
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  logic [W-1:0]        sync1_reg, sync2_reg, prev_reg;
  logic [7:0]          cnt_reg, cnt_next;
  logic                same;
  logic [DIGITS-1:0]   sel;
  logic                one_hot;
  logic                capture;
  logic [4:0]          dec;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_reg <= '1;
      sync2_reg <= '1;
      prev_reg  <= '1;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= {bus.an_n, bus.seg_n};
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      cnt_reg   <= cnt_next;
    end
  end

  assign same = (sync2_reg == prev_reg);

  always_comb begin
    cnt_next = 8'd0;
    if (same)
      cnt_next = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + 8'd1;
  end

  assign sel     = ~sync2_reg[W-1:7];
  assign one_hot = (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);
  // Fires only on the step into STABLE_CYCLES-1, so a held pattern captures once.
  assign capture = same && (cnt_reg == CNT_ARM) && one_hot;
  assign dec     = decode(~sync2_reg[6:0]);

  logic [3:0]          stage_val_reg [DIGITS];
  logic                stage_err_reg [DIGITS];
  logic                seen_reg      [DIGITS];
  logic [4*DIGITS-1:0] stage_val_vec;
  logic [DIGITS-1:0]   stage_err_vec;
  logic [DIGITS-1:0]   seen_vec;
  logic                frame_done;

  assign frame_done = &seen_vec;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_stage
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          stage_val_reg[gi] <= 4'd0;
          stage_err_reg[gi] <= 1'b0;
          seen_reg[gi]      <= 1'b0;
        end else if (capture && sel[gi]) begin
          stage_val_reg[gi] <= dec[3:0];
          stage_err_reg[gi] <= dec[4];
          seen_reg[gi]      <= 1'b1;
        end else if (frame_done) begin
          seen_reg[gi]      <= 1'b0;
        end
      end
      assign stage_val_vec[4*gi +: 4] = stage_val_reg[gi];
      assign stage_err_vec[gi]        = stage_err_reg[gi];
      assign seen_vec[gi]             = seen_reg[gi];
    end
  endgenerate

  logic [4*DIGITS-1:0] value_reg, value_next;
  logic [DIGITS-1:0]   err_reg, err_next;
  logic                valid_reg, valid_next;
  logic                overrun_reg, overrun_next;
  logic                accept;
  logic                slot_free;

  assign accept    = valid_reg && bus.frame_ready;
  assign slot_free = !valid_reg || bus.frame_ready;

  always_comb begin
    value_next   = value_reg;
    err_next     = err_reg;
    valid_next   = valid_reg;
    overrun_next = overrun_reg;
    if (accept) begin
      valid_next   = 1'b0;
      overrun_next = 1'b0;
    end
    if (frame_done) begin
      if (slot_free) begin
        value_next = stage_val_vec;
        err_next   = stage_err_vec;
        valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      value_reg   <= '0;
      err_reg     <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      value_reg   <= value_next;
      err_reg     <= err_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
    end
  end

  assign bus.value       = value_reg;
  assign bus.err         = err_reg;
  assign bus.frame_valid = valid_reg;
  assign bus.overrun     = overrun_reg;
endmodule
